spi_rx: RTL and testbench
=========================

Name: spi_rx

Overview:
- Receiving end of the team's 16-bit serial digit link.
- Sits opposite the serial transmitter on the same `clk`.
- Samples `data_in` MSB-first while `ss` is high and deserializes one frame {4 don't-care bits, 4-bit address, 8-bit digit}.
- Writes the digit into a 16-entry digit register bank that the display/readout logic reads through a registered read port.

Parameters:
FRAME_BITS, 16, bits per frame (fixed format; other values unsupported)
ADDR_W, 4, address field width, frame bits [11:8]
DATA_W, 8, digit field width, frame bits [7:0]

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
ss  in  1  frame select, active high; one frame per high window
data_in  in  1  serial data, MSB first, sampled on posedge clk while ss=1
rd_addr  in  4  digit bank read address
rd_data  out  8  registered digit bank read data
addr_out  out  4  address of last completed frame
data_out  out  8  digit of last completed frame
frame_valid  out  1  one-cycle pulse: frame completed and written
frame_err  out  1  one-cycle pulse: ss fell mid-frame
busy  out  1  high while a frame is partially received (state SHIFT)

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, bit counter=0, shift register=0.
  - All 16 bank entries=0.
  - rd_data, addr_out, data_out=0; frame_valid, frame_err, busy=0.
  - Reset dominates all other events. A frame in progress is discarded with no frame_err.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - ss=1 at posedge: sample data_in as bit 15, cnt=1, go to SHIFT.
  - ss=0: stay.
- SHIFT:
  - Each posedge with ss=1: shreg <= {shreg[14:0], data_in}, cnt+1.
  - On the edge that samples the 16th bit (cnt==15), compute frame F = {shreg[14:0], data_in}. On that same edge:
    - addr_out <= F[11:8], data_out <= F[7:0].
    - bank[F[11:8]] <= F[7:0].
    - frame_valid <= 1 for exactly one cycle.
    - cnt <= 0, go to HOLD.
  - F[15:12] is ignored and never checked.
  - Latency: frame_valid is high in the cycle immediately after the 16th sampling edge.
  - ss=0 at a posedge while in SHIFT (1..15 bits received): frame_err <= 1 for one cycle, no bank write, addr_out/data_out unchanged, cnt=0, go to IDLE.
- HOLD:
  - ss still high: further data_in bits are ignored; no error, no second frame.
  - ss=0: go to IDLE.
  - A new frame requires ss low for at least one posedge.
- busy = (state==SHIFT). It is low in IDLE and in HOLD.
- Read port:
  - rd_data <= bank[rd_addr] on every posedge; one-cycle latency.
  - Same-edge write and read to the same address: rd_data takes the newly written value (write-first bypass).
- addr_out and data_out hold their value until the next completed frame.
- cnt is 4 bits and never wraps within SHIFT; the 16th bit always exits SHIFT.

Test Plan:
- Reset, then ss=1 for 16 cycles shifting 16'hF5A5 -> frame_valid high exactly one cycle after the 16th edge; addr_out=4'h5, data_out=8'hA5. Then rd_addr=5 -> rd_data=8'hA5 one cycle later. All other entries read 0.
- ss=1 for 7 bits of 16'h0312, then ss=0 -> frame_err one-cycle pulse, no frame_valid; bank[3] stays 0; addr_out/data_out unchanged; busy falls with the pulse.
- ss held high for 24 cycles with frame 16'h0C7E followed by 8 extra 1-bits -> exactly one frame_valid; bank[12]=8'h7E; busy low during the last 8 cycles.
- Frames 16'h0011 and 16'h0F22 separated by one low-ss cycle -> two frame_valid pulses; bank[0]=8'h11, bank[15]=8'h22.
- rst=1 at bit 9 of a frame, then a full frame 16'h0299 -> no frame_err after the reset; bank[2]=8'h99, all other entries 0.
- rd_addr=6 held while frame 16'h0633 completes -> rd_data=8'h33 in the same cycle frame_valid is high (write-first).

Source files
------------

// File: rtl/spi_rx.sv
// Serial digit-link receiver: deserializes 16-bit MSB-first frames {4 x, addr, digit} into a 16-entry digit bank.
// Latency: frame_valid 1 cycle after the 16th sampling edge; rd_data 1 cycle after rd_addr. No backpressure.
module spi_rx #(
    parameter int FRAME_BITS = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int KEEP_W = ADDR_W + DATA_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    // Only the low addr+digit bits are kept; the don't-care nibble shifts off the top.
    logic [KEEP_W-2:0]   shreg_q;
    logic [DATA_W-1:0]   bank_q [DEPTH];
    logic [DATA_W-1:0]   rd_data_q;
    logic [ADDR_W-1:0]   addr_out_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                frame_valid_q;
    logic                frame_err_q;
    logic                busy_q;

    logic [KEEP_W-1:0]   frame_d;
    logic [ADDR_W-1:0]   waddr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wr_en_d;

    assign frame_d = {shreg_q, data_in};
    assign waddr_d = frame_d[KEEP_W-1:DATA_W];
    assign wdata_d = frame_d[DATA_W-1:0];
    assign wr_en_d = (state_q == SHIFT) && ss && (cnt_q == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            rd_data_q     <= '0;
            addr_out_q    <= '0;
            data_out_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            // Write-first: a read of the address being written sees the new digit.
            rd_data_q <= (wr_en_d && (waddr_d == rd_addr)) ? wdata_d : bank_q[rd_addr];
            if (wr_en_d) bank_q[waddr_d] <= wdata_d;

            case (state_q)
                IDLE: begin
                    if (ss) begin
                        shreg_q <= {{(KEEP_W-2){1'b0}}, data_in};
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!ss) begin
                        frame_err_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else if (wr_en_d) begin
                        addr_out_q    <= waddr_d;
                        data_out_q    <= wdata_d;
                        frame_valid_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= HOLD;
                        busy_q        <= 1'b0;
                    end else begin
                        shreg_q <= frame_d[KEEP_W-2:0];
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!ss) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data     = rd_data_q;
    assign addr_out    = addr_out_q;
    assign data_out    = data_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: directed scenarios plus random frames, compared every cycle against a
// window-based model (bits collected per ss-high window; the 16th bit completes a frame).
module tb_spi_rx;
    logic       clk = 1'b0;
    logic       rst, ss, data_in;
    logic [3:0] rd_addr;
    logic [7:0] rd_data, data_out;
    logic [3:0] addr_out;
    logic       frame_valid, frame_err, busy;

    spi_rx dut (
        .clk(clk), .rst(rst), .ss(ss), .data_in(data_in), .rd_addr(rd_addr),
        .rd_data(rd_data), .addr_out(addr_out), .data_out(data_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         win_q[$];
    logic [7:0] m_bank [16];
    logic [7:0] e_rd, e_data;
    logic [3:0] e_addr;
    logic       e_valid, e_err, e_busy;
    int         n_valid = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic d, input logic [3:0] ra);
        logic [15:0] f;
        if (r) begin
            win_q.delete();
            for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
            e_rd = 0; e_addr = 0; e_data = 0; e_valid = 0; e_err = 0; e_busy = 0;
            return;
        end
        e_valid = 0;
        e_err   = 0;
        if (s) begin
            if (win_q.size() < 17) win_q.push_back(d);
            if (win_q.size() == 16) begin
                f = '0;
                for (int i = 0; i < 16; i++) f = {f[14:0], win_q[i]};
                m_bank[f[11:8]] = f[7:0];
                e_addr  = f[11:8];
                e_data  = f[7:0];
                e_valid = 1;
            end
        end else begin
            if (win_q.size() > 0 && win_q.size() < 16) e_err = 1;
            win_q.delete();
        end
        e_busy = (win_q.size() > 0) && (win_q.size() < 16);
        e_rd   = m_bank[ra];
    endtask

    task automatic step(input logic r, input logic s, input logic d);
        rst = r; ss = s; data_in = d;
        @(posedge clk);
        model_edge(r, s, d, rd_addr);
        #1;
        check("frame_valid", frame_valid, e_valid);
        check("frame_err", frame_err, e_err);
        check("busy", busy, e_busy);
        check("addr_out", addr_out, e_addr);
        check("data_out", data_out, e_data);
        check("rd_data", rd_data, e_rd);
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) step(1'b0, 1'b1, f[15 - (i % 16)]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic sweep_bank();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1; ss = 0; data_in = 0; rd_addr = 0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Basic frame, valid timing, readback
        rd_addr = 0;
        send(16'hF5A5, 15);
        check("no_early_valid", frame_valid, 1'b0);
        send(16'hF5A5 << 15, 1);
        check("f5a5_valid", frame_valid, 1'b1);
        check("f5a5_addr", addr_out, 4'h5);
        check("f5a5_data", data_out, 8'hA5);
        idle(1);
        rd_addr = 5;
        idle(1);
        check("bank5_rd", rd_data, 8'hA5);
        sweep_bank();

        // Truncated frame
        n_valid = 0; n_err = 0;
        send(16'h0312, 7);
        check("busy_mid", busy, 1'b1);
        idle(1);
        check("trunc_err", frame_err, 1'b1);
        check("trunc_busy", busy, 1'b0);
        check("trunc_addr_kept", addr_out, 4'h5);
        idle(2);
        check("trunc_err_pulses", n_err, 1);
        check("trunc_no_valid", n_valid, 0);
        rd_addr = 3;
        idle(1);
        check("bank3_zero", rd_data, 8'h00);

        // Held ss with 8 extra ones
        n_valid = 0;
        send(16'h0C7E, 16);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("hold_busy_low", busy, 1'b0);
        end
        idle(1);
        check("hold_one_valid", n_valid, 1);
        rd_addr = 12;
        idle(1);
        check("bank12", rd_data, 8'h7E);

        // Back-to-back with one low cycle
        n_valid = 0;
        send(16'h0011, 16);
        idle(1);
        send(16'h0F22, 16);
        idle(1);
        check("b2b_two_valid", n_valid, 2);
        sweep_bank();

        // Reset mid-frame then a full frame
        n_err = 0;
        send(16'h0455, 9);
        step(1'b1, 1'b1, 1'b0);
        idle(1);
        send(16'h0299, 16);
        idle(1);
        check("rst_no_err", n_err, 0);
        sweep_bank();

        // Write-first bypass
        rd_addr = 6;
        send(16'h0633, 16);
        check("wf_valid", frame_valid, 1'b1);
        check("wf_rd", rd_data, 8'h33);
        idle(1);

        // Random frames: random truncation, hold tail, gaps, read addresses, occasional reset
        for (int k = 0; k < 60; k++) begin
            logic [15:0] f;
            int nb;
            f = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 20);
            for (int i = 0; i < nb; i++) begin
                rd_addr = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 199) == 0) step(1'b1, 1'b1, 1'b0);
                else step(1'b0, 1'b1, (i < 16) ? f[15 - i] : 1'($urandom_range(0, 1)));
            end
            idle($urandom_range(1, 3));
        end
        sweep_bank();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
